// File: rtl/snake_engine.sv
// Snake movement engine: circular segment buffer, wall/wrap handling,
// sequential self-collision scan and an indexed segment read port.
module snake_engine #(
  parameter int SIZE_X   = 40,
  parameter int SIZE_Y   = 30,
  parameter int MAX_LEN  = 256,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 20,
  parameter int START_Y  = 15,
  parameter int WRAP     = 0,
  parameter int XW       = $clog2(SIZE_X),
  parameter int YW       = $clog2(SIZE_Y),
  parameter int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          step,
  input  logic          grow,
  input  logic [1:0]    dir,
  input  logic [LW-1:0] rd_idx,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  output logic          rd_valid,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  output logic          busy,
  output logic          step_done,
  output logic          dead,
  output logic [1:0]    dead_cause
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int SW = XW + YW;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CALC, S_SCAN, S_COMMIT, S_DEAD} state_t;
  state_t state_reg, state_next;

  logic [SW-1:0] seg_mem [MAX_LEN];
  logic [SW-1:0] scan_q_reg, rd_word_reg;
  logic          rd_valid_reg;

  logic [PW-1:0] head_ptr_reg;
  logic [XW-1:0] head_x_reg, new_x_reg, calc_x;
  logic [YW-1:0] head_y_reg, new_y_reg, calc_y;
  logic [LW-1:0] len_reg, ns_reg, scan_cnt_reg, init_cnt_reg;
  logic [1:0]    cur_dir_reg, dead_cause_reg;
  logic          grow_pending_reg, grow_eff_reg, step_done_reg;
  logic          calc_wall, scan_hit, grow_ok, accept;
  logic          wr_en;
  logic [PW-1:0] wr_addr, ptr_inc;
  logic [SW-1:0] wr_data;

  // Physical slot of segment idx, counting backwards from the head slot.
  function automatic logic [PW-1:0] seg_addr(input logic [PW-1:0] ptr, input logic [LW-1:0] idx);
    logic [LW:0] sum;
    sum = (LW+1)'(ptr) + (LW+1)'(MAX_LEN) - {1'b0, idx};
    if (sum >= (LW+1)'(MAX_LEN)) sum = sum - (LW+1)'(MAX_LEN);
    return PW'(sum);
  endfunction

  assign ptr_inc  = (head_ptr_reg == PW'(MAX_LEN - 1)) ? '0 : head_ptr_reg + PW'(1);
  assign grow_ok  = grow_pending_reg && (len_reg < LW'(MAX_LEN));
  assign accept   = (state_reg == S_IDLE) && step && start;
  assign scan_hit = (scan_cnt_reg != '0) && (scan_q_reg == {new_y_reg, new_x_reg});

  always_comb begin
    calc_x    = head_x_reg;
    calc_y    = head_y_reg;
    calc_wall = 1'b0;
    case (cur_dir_reg)
      2'b00: if (head_x_reg == XW'(SIZE_X - 1)) begin
               calc_x = '0;
               calc_wall = (WRAP == 0);
             end else calc_x = head_x_reg + XW'(1);
      2'b01: if (head_y_reg == '0) begin
               calc_y = YW'(SIZE_Y - 1);
               calc_wall = (WRAP == 0);
             end else calc_y = head_y_reg - YW'(1);
      2'b10: if (head_x_reg == '0) begin
               calc_x = XW'(SIZE_X - 1);
               calc_wall = (WRAP == 0);
             end else calc_x = head_x_reg - XW'(1);
      default: if (head_y_reg == YW'(SIZE_Y - 1)) begin
               calc_y = '0;
               calc_wall = (WRAP == 0);
             end else calc_y = head_y_reg + YW'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_INIT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    case (state_reg)
      S_INIT: begin
        wr_en   = 1'b1;
        wr_addr = seg_addr(head_ptr_reg, init_cnt_reg);
        wr_data = {YW'(START_Y), XW'(START_X) - XW'(init_cnt_reg)};
        if (init_cnt_reg == LW'(INIT_LEN - 1)) state_next = S_IDLE;
      end
      S_IDLE:   if (step && start) state_next = S_CALC;
      S_CALC:   state_next = calc_wall ? S_DEAD : S_SCAN;
      // Compare lags the address by one cycle because of the registered read.
      S_SCAN: begin
        if (scan_hit) state_next = S_DEAD;
        else if (scan_cnt_reg == ns_reg) state_next = S_COMMIT;
      end
      S_COMMIT: begin
        wr_en      = 1'b1;
        wr_addr    = ptr_inc;
        wr_data    = {new_y_reg, new_x_reg};
        state_next = S_IDLE;
      end
      S_DEAD:   state_next = S_DEAD;
      default:  state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) seg_mem[wr_addr] <= wr_data;
    scan_q_reg  <= seg_mem[seg_addr(head_ptr_reg, scan_cnt_reg)];
    rd_word_reg <= seg_mem[seg_addr(head_ptr_reg, rd_idx)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr_reg     <= '0;
      head_x_reg       <= XW'(START_X);
      head_y_reg       <= YW'(START_Y);
      len_reg          <= LW'(INIT_LEN);
      cur_dir_reg      <= 2'b00;
      grow_pending_reg <= 1'b0;
      grow_eff_reg     <= 1'b0;
      new_x_reg        <= '0;
      new_y_reg        <= '0;
      ns_reg           <= '0;
      scan_cnt_reg     <= '0;
      init_cnt_reg     <= '0;
      dead_cause_reg   <= 2'b00;
      step_done_reg    <= 1'b0;
      rd_valid_reg     <= 1'b0;
    end else begin
      step_done_reg <= (state_reg == S_COMMIT);
      rd_valid_reg  <= (rd_idx < len_reg);
      if (state_reg == S_INIT) init_cnt_reg <= init_cnt_reg + LW'(1);
      if (accept) cur_dir_reg <= (dir == (cur_dir_reg ^ 2'b10)) ? cur_dir_reg : dir;
      if (state_reg == S_CALC) begin
        new_x_reg    <= calc_x;
        new_y_reg    <= calc_y;
        grow_eff_reg <= grow_ok;
        ns_reg       <= grow_ok ? len_reg : len_reg - LW'(1);
        scan_cnt_reg <= '0;
        if (calc_wall) dead_cause_reg <= 2'b01;
      end
      if (state_reg == S_SCAN) begin
        scan_cnt_reg <= scan_cnt_reg + LW'(1);
        if (scan_hit) dead_cause_reg <= 2'b10;
      end
      if (state_reg == S_COMMIT) begin
        head_ptr_reg <= ptr_inc;
        head_x_reg   <= new_x_reg;
        head_y_reg   <= new_y_reg;
        if (grow_eff_reg) len_reg <= len_reg + LW'(1);
      end
      // A grow pulse landing on the consuming commit re-arms for the next move.
      if (state_reg == S_COMMIT && grow_eff_reg) grow_pending_reg <= grow;
      else if (grow && state_reg != S_DEAD) grow_pending_reg <= 1'b1;
    end
  end

  assign rd_x       = rd_valid_reg ? rd_word_reg[XW-1:0] : '0;
  assign rd_y       = rd_valid_reg ? rd_word_reg[SW-1:XW] : '0;
  assign rd_valid   = rd_valid_reg;
  assign head_x     = head_x_reg;
  assign head_y     = head_y_reg;
  assign length     = len_reg;
  assign busy       = (state_reg == S_INIT) || (state_reg == S_CALC) ||
                      (state_reg == S_SCAN) || (state_reg == S_COMMIT);
  assign step_done  = step_done_reg;
  assign dead       = (state_reg == S_DEAD);
  assign dead_cause = dead_cause_reg;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: a wall instance and a wrap instance share one stimulus
// stream; directed table, corner sequences and random moves against a model.
module tb_snake_engine;
  localparam int XW = 6;
  localparam int YW = 5;
  localparam int LW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, step = 1'b0, grow = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [LW-1:0] rd_idx = '0;
  logic [XW-1:0] rd_x [2];
  logic [YW-1:0] rd_y [2];
  logic [XW-1:0] head_x [2];
  logic [YW-1:0] head_y [2];
  logic [LW-1:0] length [2];
  logic rd_valid [2], busy [2], step_done [2], dead [2];
  logic [1:0] dead_cause [2];

  always #5 clk = ~clk;

  snake_engine #(.WRAP(0)) dut_wall (
    .clk(clk), .rst(rst), .start(start), .step(step), .grow(grow), .dir(dir),
    .rd_idx(rd_idx), .rd_x(rd_x[0]), .rd_y(rd_y[0]), .rd_valid(rd_valid[0]),
    .head_x(head_x[0]), .head_y(head_y[0]), .length(length[0]), .busy(busy[0]),
    .step_done(step_done[0]), .dead(dead[0]), .dead_cause(dead_cause[0]));

  snake_engine #(.WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .start(start), .step(step), .grow(grow), .dir(dir),
    .rd_idx(rd_idx), .rd_x(rd_x[1]), .rd_y(rd_y[1]), .rd_valid(rd_valid[1]),
    .head_x(head_x[1]), .head_y(head_y[1]), .length(length[1]), .busy(busy[1]),
    .step_done(step_done[1]), .dead(dead[1]), .dead_cause(dead_cause[1]));

  int checks = 0;
  int errors = 0;

  // Reference model: body as a plain list, index 0 = head; instance 1 wraps.
  int m_x [2][257];
  int m_y [2][257];
  int m_len [2], m_dir [2], m_dead [2], m_cause [2], m_gp [2];
  int exp_lat [2], got_lat [2];

  typedef struct {
    int op;     // 0 step, 1 grow pulse, 2 reset
    int d, st, extra;
    int hx, hy, len, tx, ty, lat, dd, cause;
  } vec_t;
  vec_t tbl [19];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_len[k] = 3; m_dir[k] = 0; m_dead[k] = 0; m_cause[k] = 0; m_gp[k] = 0;
      for (int i = 0; i < 3; i++) begin
        m_x[k][i] = 20 - i;
        m_y[k][i] = 15;
      end
    end
  endtask

  task automatic model_step(input int k, input int d, input int st, output int lat);
    int nd, nx, ny, geff, ns;
    lat = -1;
    if (m_dead[k] != 0 || st == 0) return;
    nd = (d == (m_dir[k] ^ 2)) ? m_dir[k] : d;
    m_dir[k] = nd;
    nx = m_x[k][0]; ny = m_y[k][0];
    case (nd)
      0: nx = nx + 1;
      1: ny = ny - 1;
      2: nx = nx - 1;
      default: ny = ny + 1;
    endcase
    if (nx < 0 || nx > 39 || ny < 0 || ny > 29) begin
      if (k == 0) begin
        m_dead[k] = 1; m_cause[k] = 1;
        return;
      end
      nx = (nx + 40) % 40;
      ny = (ny + 30) % 30;
    end
    geff = (m_gp[k] != 0 && m_len[k] < 256) ? 1 : 0;
    ns = (geff != 0) ? m_len[k] : m_len[k] - 1;
    for (int i = 0; i < ns; i++)
      if (m_x[k][i] == nx && m_y[k][i] == ny) begin
        m_dead[k] = 1; m_cause[k] = 2;
        return;
      end
    for (int i = m_len[k]; i > 0; i--) begin
      m_x[k][i] = m_x[k][i-1];
      m_y[k][i] = m_y[k][i-1];
    end
    m_x[k][0] = nx; m_y[k][0] = ny;
    if (geff != 0) begin
      m_len[k]++;
      m_gp[k] = 0;
    end
    lat = ns + 3;
  endtask

  task automatic check_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_head_x%0d", tag, k), int'(head_x[k]), m_x[k][0]);
      check($sformatf("%s_head_y%0d", tag, k), int'(head_y[k]), m_y[k][0]);
      check($sformatf("%s_length%0d", tag, k), int'(length[k]), m_len[k]);
      check($sformatf("%s_dead%0d", tag, k), int'(dead[k]), m_dead[k]);
      check($sformatf("%s_cause%0d", tag, k), int'(dead_cause[k]), m_cause[k]);
    end
  endtask

  task automatic check_read(input int idx);
    int v;
    rd_idx = LW'(idx);
    tick();
    for (int k = 0; k < 2; k++) begin
      v = (idx < m_len[k]) ? 1 : 0;
      check($sformatf("rd_valid%0d_idx%0d", k, idx), int'(rd_valid[k]), v);
      check($sformatf("rd_x%0d_idx%0d", k, idx), int'(rd_x[k]), (v != 0) ? m_x[k][idx] : 0);
      check($sformatf("rd_y%0d_idx%0d", k, idx), int'(rd_y[k]), (v != 0) ? m_y[k][idx] : 0);
    end
    $display("read idx=%0d -> wall(%0d,%0d,v%0d) wrap(%0d,%0d,v%0d)", idx,
             rd_x[0], rd_y[0], rd_valid[0], rd_x[1], rd_y[1], rd_valid[1]);
  endtask

  task automatic do_reset();
    int e;
    rst = 1'b1; step = 1'b0; grow = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_busy%0d", k), int'(busy[k]), 1);
      check($sformatf("rst_rd_valid%0d", k), int'(rd_valid[k]), 0);
      check($sformatf("rst_rd_x%0d", k), int'(rd_x[k]), 0);
      check($sformatf("rst_step_done%0d", k), int'(step_done[k]), 0);
      check($sformatf("rst_dead%0d", k), int'(dead[k]), 0);
      check($sformatf("rst_cause%0d", k), int'(dead_cause[k]), 0);
      check($sformatf("rst_head_x%0d", k), int'(head_x[k]), 20);
      check($sformatf("rst_length%0d", k), int'(length[k]), 3);
    end
    rst = 1'b0;
    model_reset();
    for (e = 1; e <= 20; e++) begin
      tick();
      if (!busy[0] && !busy[1]) break;
    end
    check("init_busy_cycles", e, 3);
    $display("reset: init took %0d cycles", e);
  endtask

  task automatic do_grow();
    grow = 1'b1;
    tick();
    grow = 1'b0;
    for (int k = 0; k < 2; k++) if (m_dead[k] == 0) m_gp[k] = 1;
    $display("grow pulse");
  endtask

  task automatic do_step(input int d, input int st, input int extra);
    int e;
    for (int k = 0; k < 2; k++) begin
      model_step(k, d, st, exp_lat[k]);
      got_lat[k] = -1;
    end
    step = 1'b1; dir = 2'(d); start = st[0];
    tick();
    for (e = 1; e <= 600; e++) begin
      step = (e == extra);
      tick();
      for (int k = 0; k < 2; k++) if (step_done[k] && got_lat[k] < 0) got_lat[k] = e;
      if (!busy[0] && !busy[1]) break;
    end
    step = 1'b0;
    if (e > 600) check("step_timeout", e, 600);
    for (int k = 0; k < 2; k++)
      check($sformatf("step_latency%0d", k), got_lat[k], exp_lat[k]);
    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("step_done_width%0d", k), int'(step_done[k]), 0);
      check($sformatf("no_queued_step%0d", k), int'(busy[k]), 0);
    end
    $display("step dir=%0d start=%0d: wall(%0d,%0d) len%0d lat%0d dead%0d | wrap(%0d,%0d) len%0d lat%0d dead%0d",
             d, st, head_x[0], head_y[0], length[0], got_lat[0], dead[0],
             head_x[1], head_y[1], length[1], got_lat[1], dead[1]);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int op, idx;
    tbl[0]  = '{2, 0, 0, 0, 20, 15, 3, 18, 15, -1, 0, 0};
    tbl[1]  = '{0, 0, 1, 2, 21, 15, 3, 19, 15,  5, 0, 0};
    tbl[2]  = '{0, 2, 1, 0, 22, 15, 3, 20, 15,  5, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 22, 15, 3, 20, 15, -1, 0, 0};
    tbl[4]  = '{2, 0, 0, 0, 20, 15, 3, 18, 15, -1, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 20, 15, 3, 18, 15, -1, 0, 0};
    tbl[6]  = '{0, 0, 1, 0, 21, 15, 4, 18, 15,  6, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 21, 15, 4, 18, 15, -1, 0, 0};
    tbl[8]  = '{0, 0, 1, 0, 22, 15, 5, 18, 15,  7, 0, 0};
    tbl[9]  = '{0, 3, 1, 0, 22, 16, 5, 19, 15,  7, 0, 0};
    tbl[10] = '{0, 2, 1, 0, 21, 16, 5, 20, 15,  7, 0, 0};
    tbl[11] = '{0, 1, 1, 0, 21, 16, 5, 20, 15, -1, 1, 2};
    tbl[12] = '{0, 0, 1, 0, 21, 16, 5, 20, 15, -1, 1, 2};
    tbl[13] = '{2, 0, 0, 0, 20, 15, 3, 18, 15, -1, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 20, 15, 3, 18, 15, -1, 0, 0};
    tbl[15] = '{0, 0, 1, 0, 21, 15, 4, 18, 15,  6, 0, 0};
    tbl[16] = '{0, 3, 1, 0, 21, 16, 4, 19, 15,  6, 0, 0};
    tbl[17] = '{0, 2, 1, 0, 20, 16, 4, 20, 15,  6, 0, 0};
    tbl[18] = '{0, 1, 1, 0, 20, 15, 4, 21, 15,  6, 0, 0};

    model_reset();
    for (int i = 0; i < 19; i++) begin
      case (tbl[i].op)
        2: do_reset();
        1: do_grow();
        default: do_step(tbl[i].d, tbl[i].st, tbl[i].extra);
      endcase
      for (int k = 0; k < 2; k++) begin
        check($sformatf("tbl%0d_head_x%0d", i, k), int'(head_x[k]), tbl[i].hx);
        check($sformatf("tbl%0d_head_y%0d", i, k), int'(head_y[k]), tbl[i].hy);
        check($sformatf("tbl%0d_length%0d", i, k), int'(length[k]), tbl[i].len);
        check($sformatf("tbl%0d_dead%0d", i, k), int'(dead[k]), tbl[i].dd);
        check($sformatf("tbl%0d_cause%0d", i, k), int'(dead_cause[k]), tbl[i].cause);
        if (tbl[i].op == 0) check($sformatf("tbl%0d_latency%0d", i, k), got_lat[k], tbl[i].lat);
      end
      rd_idx = LW'(tbl[i].len - 1);
      tick();
      for (int k = 0; k < 2; k++) begin
        check($sformatf("tbl%0d_tail_x%0d", i, k), int'(rd_x[k]), tbl[i].tx);
        check($sformatf("tbl%0d_tail_y%0d", i, k), int'(rd_y[k]), tbl[i].ty);
      end
      if (tbl[i].op == 2) begin
        check_read(0);
        check_read(1);
      end
      check_read(tbl[i].len);
      check_state($sformatf("tbl%0d_model", i));
    end

    // Edge behaviour: head to x = 39, then one more step right.
    do_reset();
    for (int i = 0; i < 19; i++) do_step(0, 1, 0);
    check("edge_head_x_wall", int'(head_x[0]), 39);
    do_step(0, 1, 0);
    check("wall_dead", int'(dead[0]), 1);
    check("wall_cause", int'(dead_cause[0]), 1);
    check("wall_head_x", int'(head_x[0]), 39);
    check("wall_busy", int'(busy[0]), 0);
    check("wrap_head_x", int'(head_x[1]), 0);
    check("wrap_length", int'(length[1]), 3);
    check("wrap_dead", int'(dead[1]), 0);
    check_read(1);
    check_read(2);

    // Reset while the body scan is running.
    do_reset();
    step = 1'b1; dir = 2'b00; start = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    check("mid_scan_busy", int'(busy[0]), 1);
    do_reset();
    check_read(0);
    check_read(1);
    check_read(2);
    check_read(3);
    check_state("after_mid_scan_rst");

    // Randomised moves against the model.
    for (int r = 0; r < 300; r++) begin
      if (r % 60 == 0) do_reset();
      op = $urandom_range(0, 9);
      if (op < 3) do_grow();
      else if (op < 9) begin
        do_step($urandom_range(0, 3), ($urandom_range(0, 7) != 0) ? 1 : 0, 0);
        check_state($sformatf("rnd%0d", r));
      end else begin
        idx = $urandom_range(0, m_len[1] + 1);
        check_read(idx);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
Parametrised snake movement engine that replaces the fixed-size snake calculator. Snake body is held in a circular segment buffer of depth MAX_LEN; each step computes the new head, checks walls (or wraps) and checks self-collision with a sequential body scan. The engine sits between tick_timer/key_control and the field calculator. Body segments are exposed through an indexed read port, so the wide flattened snake_xy bus is no longer needed.

Parameters:
SIZE_X, 40, grid width in cells; XW = $clog2(SIZE_X)
SIZE_Y, 30, grid height in cells; YW = $clog2(SIZE_Y)
MAX_LEN, 256, segment buffer depth (max snake length); LW = $clog2(MAX_LEN+1)
INIT_LEN, 3, length after reset (2..MAX_LEN)
START_X, 20, head x after reset
START_Y, 15, head y after reset
WRAP, 0, 1 = wrap at edges, 0 = wall kills

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  enable; step ignored while low
step  in  1  one-cycle move request (tick)
grow  in  1  one-cycle grow request, latched until next commit
dir  in  2  requested direction: 00 right, 01 up (y-1), 10 left, 11 down (y+1)
rd_idx  in  LW  segment index, 0 = head
rd_x  out  XW  segment x, registered
rd_y  out  YW  segment y, registered
rd_valid  out  1  rd_idx < length, registered
head_x  out  XW  current head x
head_y  out  YW  current head y
length  out  LW  current length
busy  out  1  high in INIT/CALC/SCAN/COMMIT
step_done  out  1  one-cycle pulse after a committed move
dead  out  1  sticky game-over flag
dead_cause  out  2  00 none, 01 wall, 10 self

Behaviour:
- Storage: circular buffer with head_ptr. Segment i is at (head_ptr - i) mod MAX_LEN.
- States: INIT, IDLE, CALC, SCAN, COMMIT, DEAD.
- rst (any state, mid-step included) -> INIT. Clears dead, dead_cause, grow_pending, step_done. Sets cur_dir = 00 and length = INIT_LEN. INIT writes segment i = (START_X - i, START_Y) one per cycle for INIT_LEN cycles with busy = 1, then goes to IDLE. head_x/head_y = START_X/START_Y from the reset edge.
- IDLE: step & start sampled high -> CALC; dir is latched. If dir is the opposite of cur_dir, cur_dir is kept (reversal rejected); otherwise cur_dir = dir. step outside IDLE (busy or DEAD) is dropped, not queued.
- grow: a pulse in any non-DEAD state sets grow_pending. grow_pending is ignored if length == MAX_LEN.
- CALC (1 cycle): new head = head + cur_dir.
  - WRAP = 1: x = SIZE_X-1 +1 -> 0, x = 0 -1 -> SIZE_X-1; same for y.
  - WRAP = 0: leaving the grid -> DEAD with cause 01; head and buffer are unchanged.
- SCAN: compares the new head with segments 0..Ns-1, one per cycle. Ns = length when grow is effective, else length-1 (the vacating tail is legal to enter). A match -> DEAD with cause 10, nothing written.
- COMMIT (1 cycle): head_ptr+1 mod MAX_LEN, new head written, head_x/head_y updated. length+1 if grow is effective, then grow_pending clears.
- step_done is high for exactly one cycle, Ns+3 edges after the accepting edge. The new head/length are visible in that cycle. busy is low in that cycle.
- DEAD: dead = 1 and busy = 0; steps are ignored until rst.
- Read port: 1-cycle latency; a read on the same edge as a COMMIT write returns the old data. rd_idx >= length gives rd_valid = 0 and rd_x = rd_y = 0.
- Reset values: rd_x = rd_y = 0, rd_valid = 0, step_done = 0, dead = 0, dead_cause = 00, busy = 1.

Test Plan:
- Reset with defaults, wait for busy = 0 (3 cycles) -> rd_idx 0/1/2 read (20,15), (19,15), (18,15); length = 3; rd_idx = 3 gives rd_valid = 0.
- step with dir = 00 -> head (21,15), tail (19,15), length 3; step_done exactly 5 edges after the accepting edge; a second step while busy is dropped.
- After moving right, step with dir = 10 -> head (22,15), reversal rejected; a step with start = 0 gives no movement.
- grow pulse, then step -> length 4, tail unchanged, step_done 6 edges after acceptance.
- Grow to length 5 in a line with head (22,15), then step down, left, up -> the third step hits segment 3 at (21,15): dead = 1, cause 10, head stays (21,16); a length-4 square into the tail is legal.
- WRAP = 0: head x = 39, step right -> dead, cause 01. WRAP = 1: same move -> head x = 0, length unchanged. rst mid-SCAN -> reinitialised, busy for 3 cycles.
